// File: rtl/bu_mac_sched_if.sv
// MAC-side bus between the bu_mac_sched sequencer (master) and the bu_nlower
// multiply-accumulate pipeline (slave).
interface bu_mac_sched_if;
  logic [31:0] dataa_mul;
  logic [31:0] datab_mul;
  logic [31:0] data_b_accum;
  logic        data_in_flag;
  logic [31:0] mac_result;
  logic        mac_valid;
  logic        mac_ovf;
  logic        mac_unf;

  modport master (
    output dataa_mul, datab_mul, data_b_accum, data_in_flag,
    input  mac_result, mac_valid, mac_ovf, mac_unf
  );

  modport slave (
    input  dataa_mul, datab_mul, data_b_accum, data_in_flag,
    output mac_result, mac_valid, mac_ovf, mac_unf
  );
endinterface

// File: rtl/bu_mac_sched.sv
// Issues interleaved dot-product terms into a LAT-deep MAC pipeline, tracks the
// in-flight tags and writes partial sums back, stalling on read-after-write hazards.
module bu_mac_sched #(
  parameter int LAT   = 11,
  parameter int MAX_N = 16,
  parameter int NW    = 4,
  parameter int KW    = 8
) (
  input  logic           clock,
  input  logic           aclr,
  input  logic           start,
  input  logic [NW:0]    n_out,
  input  logic [KW-1:0]  k_len,
  output logic [NW-1:0]  op_j,
  output logic [KW-1:0]  op_k,
  input  logic [31:0]    op_a,
  input  logic [31:0]    op_b,
  bu_mac_sched_if.master mac,
  output logic           res_valid,
  output logic [NW-1:0]  res_idx,
  output logic [31:0]    res_data,
  output logic           busy,
  output logic           done,
  output logic           err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [NW:0] N_MAX = (NW+1)'(MAX_N);
  localparam logic [NW:0] N_ONE = (NW+1)'(1);

  state_t         state;
  state_t         state_nx;
  logic [NW-1:0]  n_m1;
  logic [KW-1:0]  k_m1;
  logic [MAX_N-1:0] pend;
  logic [31:0]    psum [MAX_N];
  logic [LAT-1:0] tag_v;
  logic [LAT-1:0] tag_last;
  logic [NW-1:0]  tag_j [LAT];

  logic [NW:0]    n_sat;
  logic [NW-1:0]  tail_j;
  logic           accept;
  logic           empty_req;
  logic           tail_v;
  logic           wb_hit;
  logic           bypass;
  logic           blocked;
  logic           last_issue;
  logic           pipe_busy;
  logic           mac_fault;
  logic           issue;

  assign n_sat      = (n_out > N_MAX) ? N_MAX : n_out;
  assign accept     = (state == IDLE) && start;
  assign empty_req  = (n_out == '0) || (k_len == '0);
  assign tail_v     = tag_v[LAT-1];
  assign tail_j     = tag_j[LAT-1];
  assign wb_hit     = tail_v && mac.mac_valid;
  // A tail entry for the same row frees it this cycle, so the issue need not wait.
  assign bypass     = tail_v && (tail_j == op_j);
  assign blocked    = pend[op_j] && !bypass;
  assign last_issue = (op_j == n_m1) && (op_k == k_m1);
  assign pipe_busy  = |tag_v[LAT-2:0];
  assign mac_fault  = (tail_v && !mac.mac_valid)
                   || (mac.mac_valid && !tail_v && (state == RUN || state == DRAIN))
                   || (wb_hit && (mac.mac_ovf || mac.mac_unf));

  always_ff @(posedge clock) begin
    if (aclr) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = empty_req ? DONE : RUN;
      RUN: begin
        issue = !blocked;
        if (!blocked && last_issue) state_nx = DRAIN;
      end
      DRAIN: if (!pipe_busy) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy             = (state != IDLE);
  assign mac.data_in_flag = issue;
  assign mac.dataa_mul    = issue ? op_a : '0;
  assign mac.datab_mul    = issue ? op_b : '0;

  always_comb begin
    mac.data_b_accum = '0;
    if (issue && op_k != '0)
      mac.data_b_accum = (bypass && mac.mac_valid) ? mac.mac_result : psum[op_j];
  end

  always_ff @(posedge clock) begin
    if (wb_hit) psum[tail_j] <= mac.mac_result;
    tag_j[0] <= op_j;
    for (int i = 1; i < LAT; i++) tag_j[i] <= tag_j[i-1];
  end

  always_ff @(posedge clock) begin
    if (aclr) begin
      n_m1      <= '0;
      k_m1      <= '0;
      op_j      <= '0;
      op_k      <= '0;
      pend      <= '0;
      tag_v     <= '0;
      tag_last  <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_data  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done      <= (state == DONE);
      res_valid <= wb_hit && tag_last[LAT-1];
      if (wb_hit && tag_last[LAT-1]) begin
        res_idx  <= tail_j;
        res_data <= mac.mac_result;
      end
      tag_v    <= {tag_v[LAT-2:0], issue};
      tag_last <= {tag_last[LAT-2:0], op_k == k_m1};
      // Set after clear so a same-row write-back plus reissue leaves the row pending.
      if (tail_v) pend[tail_j] <= 1'b0;
      if (issue)  pend[op_j]   <= 1'b1;
      if (accept)         err <= 1'b0;
      else if (mac_fault) err <= 1'b1;
      if (accept) begin
        n_m1 <= NW'(n_sat - N_ONE);
        k_m1 <= k_len - KW'(1);
        op_j <= '0;
        op_k <= '0;
      end else if (issue) begin
        if (last_issue) begin
          op_j <= '0;
          op_k <= '0;
        end else if (op_j == n_m1) begin
          op_j <= '0;
          op_k <= op_k + KW'(1);
        end else begin
          op_j <= op_j + NW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bu_mac_sched.sv
// Bench for bu_mac_sched: an integer stand-in MAC with LAT-cycle latency, a schedule
// model computed from the issue/hazard rules, and a per-cycle compare process.
module tb_bu_mac_sched;
  localparam int LAT   = 11;
  localparam int MAX_N = 16;
  localparam int NW    = 4;
  localparam int KW    = 8;
  localparam int WIN   = 512;

  logic          clock = 1'b0;
  logic          aclr  = 1'b1;
  logic          start = 1'b0;
  logic [NW:0]   n_out = '0;
  logic [KW-1:0] k_len = '0;
  logic [NW-1:0] op_j;
  logic [KW-1:0] op_k;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic          res_valid;
  logic [NW-1:0] res_idx;
  logic [31:0]   res_data;
  logic          busy;
  logic          done;
  logic          err;

  bu_mac_sched_if mac_bus ();

  bu_mac_sched #(.LAT(LAT), .MAX_N(MAX_N), .NW(NW), .KW(KW)) dut (
    .clock(clock), .aclr(aclr), .start(start), .n_out(n_out), .k_len(k_len),
    .op_j(op_j), .op_k(op_k), .op_a(op_a), .op_b(op_b), .mac(mac_bus),
    .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  logic [31:0] a_mem [MAX_N][64];
  logic [31:0] b_mem [MAX_N][64];
  assign op_a = a_mem[op_j][op_k[5:0]];
  assign op_b = b_mem[op_j][op_k[5:0]];

  // Stand-in MAC: integer a*b+acc, since the sequencer only routes the data.
  logic [LAT-1:0] st_v   = '0;
  logic [LAT-1:0] st_ovf = '0;
  logic [31:0]    st_d [LAT];
  bit             inject_ovf = 1'b0;

  always @(posedge clock) begin
    st_v   <= {st_v[LAT-2:0], mac_bus.data_in_flag};
    st_ovf <= {st_ovf[LAT-2:0], inject_ovf && mac_bus.data_in_flag && op_j == '0 && op_k == '0};
    st_d[0] <= mac_bus.dataa_mul * mac_bus.datab_mul + mac_bus.data_b_accum;
    for (int i = 1; i < LAT; i++) st_d[i] <= st_d[i-1];
  end

  assign mac_bus.mac_valid  = st_v[LAT-1];
  assign mac_bus.mac_result = st_d[LAT-1];
  assign mac_bus.mac_ovf    = st_ovf[LAT-1];
  assign mac_bus.mac_unf    = 1'b0;

  logic          e_flag [WIN];
  logic          e_chk  [WIN];
  logic          e_rv   [WIN];
  logic          e_busy [WIN];
  logic          e_done [WIN];
  logic          e_err  [WIN];
  logic [NW-1:0] e_j    [WIN];
  logic [NW-1:0] e_idx  [WIN];
  logic [KW-1:0] e_k    [WIN];
  logic [31:0]   e_a    [WIN];
  logic [31:0]   e_b    [WIN];
  logic [31:0]   e_acc  [WIN];
  logic [31:0]   e_rd   [WIN];

  int          win_len = 0;
  bit          armed   = 1'b0;
  int          cur_off = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          iss_cnt, res_cnt, busy_cnt, done_off;
  int          iss_off [256];
  logic [NW-1:0] last_idx;
  logic [31:0]   last_rd;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Schedule from the rules: term (j,k) issues one cycle after the previous issue at the
  // earliest, and no sooner than LAT cycles after (j,k-1) so its partial sum is back.
  task automatic build_model(input int nreq, input int kk, input bit ovf);
    int n, t_prev, t_cur;
    int tj [MAX_N][64];
    logic [31:0] ps [MAX_N];
    n = (nreq > MAX_N) ? MAX_N : nreq;
    for (int o = 0; o < WIN; o++) begin
      e_flag[o] = 0; e_chk[o] = 0; e_rv[o] = 0; e_busy[o] = 0; e_done[o] = 0; e_err[o] = 0;
      e_j[o] = '0; e_idx[o] = '0; e_k[o] = '0; e_a[o] = '0; e_b[o] = '0; e_acc[o] = '0; e_rd[o] = '0;
    end
    for (int j = 0; j < MAX_N; j++) ps[j] = '0;
    if (n == 0 || kk == 0) begin
      win_len   = 3;
      e_busy[0] = 1;
      e_done[1] = 1;
      return;
    end
    t_prev = -1;
    for (int k = 0; k < kk; k++) begin
      for (int j = 0; j < n; j++) begin
        t_cur = t_prev + 1;
        if (k > 0 && tj[j][k-1] + LAT > t_cur) t_cur = tj[j][k-1] + LAT;
        tj[j][k] = t_cur;
        for (int o = t_prev + 1; o <= t_cur; o++) begin
          e_chk[o] = 1; e_j[o] = NW'(j); e_k[o] = KW'(k);
        end
        e_flag[t_cur] = 1;
        e_a[t_cur]    = a_mem[j][k];
        e_b[t_cur]    = b_mem[j][k];
        e_acc[t_cur]  = (k == 0) ? 32'h0 : ps[j];
        ps[j]         = a_mem[j][k] * b_mem[j][k] + e_acc[t_cur];
        if (k == kk - 1) begin
          e_rv[t_cur + LAT + 1]  = 1;
          e_idx[t_cur + LAT + 1] = NW'(j);
          e_rd[t_cur + LAT + 1]  = ps[j];
        end
        t_prev = t_cur;
      end
    end
    for (int o = 0; o <= t_prev + LAT + 1; o++) e_busy[o] = 1;
    e_done[t_prev + LAT + 2] = 1;
    win_len = t_prev + LAT + 4;
    if (ovf) for (int o = LAT + 1; o < win_len; o++) e_err[o] = 1;
  endtask

  always @(negedge clock) begin
    if (!armed) begin
      cur_off = 0;
    end else begin
      if (cur_off == 0) begin
        iss_cnt = 0; res_cnt = 0; busy_cnt = 0; done_off = -1;
      end
      if (mac_bus.data_in_flag) begin
        if (iss_cnt < 256) iss_off[iss_cnt] = cur_off;
        iss_cnt++;
      end
      if (res_valid) begin
        res_cnt++; last_idx = res_idx; last_rd = res_data;
      end
      if (busy) busy_cnt++;
      if (done) done_off = cur_off;
      checkOutput("data_in_flag", 32'(mac_bus.data_in_flag), 32'(e_flag[cur_off]));
      if (e_chk[cur_off]) begin
        checkOutput("op_j", 32'(op_j), 32'(e_j[cur_off]));
        checkOutput("op_k", 32'(op_k), 32'(e_k[cur_off]));
      end
      if (e_flag[cur_off]) begin
        checkOutput("dataa_mul", mac_bus.dataa_mul, e_a[cur_off]);
        checkOutput("datab_mul", mac_bus.datab_mul, e_b[cur_off]);
        checkOutput("data_b_accum", mac_bus.data_b_accum, e_acc[cur_off]);
      end
      checkOutput("res_valid", 32'(res_valid), 32'(e_rv[cur_off]));
      if (e_rv[cur_off]) begin
        checkOutput("res_idx", 32'(res_idx), 32'(e_idx[cur_off]));
        checkOutput("res_data", res_data, e_rd[cur_off]);
      end
      checkOutput("busy", 32'(busy), 32'(e_busy[cur_off]));
      checkOutput("done", 32'(done), 32'(e_done[cur_off]));
      checkOutput("err", 32'(err), 32'(e_err[cur_off]));
      cur_off++;
    end
  end

  task automatic fill_ops(input int fill);
    for (int j = 0; j < MAX_N; j++) begin
      for (int k = 0; k < 64; k++) begin
        case (fill)
          1:       begin a_mem[j][k] = 32'd2; b_mem[j][k] = 32'd2; end
          2:       begin a_mem[j][k] = 32'd1; b_mem[j][k] = 32'(j); end
          default: begin a_mem[j][k] = $urandom; b_mem[j][k] = $urandom; end
        endcase
      end
    end
  endtask

  task automatic applyStimulus(input int nreq, input int kk, input int fill, input bit ovf);
    fill_ops(fill);
    build_model(nreq, kk, ovf);
    inject_ovf = ovf;
    @(negedge clock);
    n_out = (NW+1)'(nreq);
    k_len = KW'(kk);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    armed = 1'b1;
    if (ovf) begin
      // A second start while busy must leave the running schedule untouched.
      repeat (5) @(posedge clock);
      #1 start = 1'b1; n_out = (NW+1)'(1); k_len = KW'(1);
      @(posedge clock);
      #1 start = 1'b0;
      repeat (win_len - 6) @(posedge clock);
    end else begin
      repeat (win_len) @(posedge clock);
    end
    #1 armed = 1'b0;
    inject_ovf = 1'b0;
  endtask

  task automatic reset_mid_run();
    fill_ops(0);
    @(negedge clock);
    n_out = (NW+1)'(8);
    k_len = KW'(4);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #1 aclr = 1'b1;
    @(posedge clock);
    #1 aclr = 1'b0;
    @(negedge clock);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_flag", 32'(mac_bus.data_in_flag), 32'h0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'h0);
    checkOutput("rst_res_data", res_data, 32'h0);
    checkOutput("rst_res_idx", 32'(res_idx), 32'h0);
    checkOutput("rst_op_j", 32'(op_j), 32'h0);
    checkOutput("rst_op_k", 32'(op_k), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    repeat (LAT + 4) begin
      @(negedge clock);
      checkOutput("late_err", 32'(err), 32'h0);
      checkOutput("late_res_valid", 32'(res_valid), 32'h0);
      checkOutput("late_busy", 32'(busy), 32'h0);
    end
  endtask

  initial begin
    fill_ops(0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);
    checkOutput("reset_res_valid", 32'(res_valid), 32'h0);
    checkOutput("reset_flag", 32'(mac_bus.data_in_flag), 32'h0);
    checkOutput("reset_op_j", 32'(op_j), 32'h0);
    @(posedge clock);
    #1 aclr = 1'b0;

    applyStimulus(1, 3, 1, 1'b0);
    checkOutput("n1_issue_count", 32'(iss_cnt), 32'd3);
    checkOutput("n1_issue1_cycle", 32'(iss_off[1]), 32'd11);
    checkOutput("n1_issue2_cycle", 32'(iss_off[2]), 32'd22);
    checkOutput("n1_result_count", 32'(res_cnt), 32'd1);
    checkOutput("n1_result", last_rd, 32'd12);
    checkOutput("n1_done_cycle", 32'(done_off), 32'd35);

    applyStimulus(16, 4, 2, 1'b0);
    checkOutput("n16_issue_count", 32'(iss_cnt), 32'd64);
    checkOutput("n16_last_issue_cycle", 32'(iss_off[63]), 32'd63);
    checkOutput("n16_last_idx", 32'(last_idx), 32'd15);
    checkOutput("n16_last_result", last_rd, 32'd60);

    applyStimulus(4, 2, 0, 1'b0);
    checkOutput("n4_issue_count", 32'(iss_cnt), 32'd8);
    checkOutput("n4_issue3_cycle", 32'(iss_off[3]), 32'd3);
    checkOutput("n4_issue4_cycle", 32'(iss_off[4]), 32'd11);

    applyStimulus(0, 5, 0, 1'b0);
    checkOutput("n0_issue_count", 32'(iss_cnt), 32'd0);
    checkOutput("n0_busy_cycles", 32'(busy_cnt), 32'd1);
    checkOutput("n0_done_cycle", 32'(done_off), 32'd1);

    applyStimulus(3, 0, 0, 1'b0);
    checkOutput("k0_issue_count", 32'(iss_cnt), 32'd0);
    checkOutput("k0_busy_cycles", 32'(busy_cnt), 32'd1);
    checkOutput("k0_done_cycle", 32'(done_off), 32'd1);

    applyStimulus(2, 2, 0, 1'b1);
    checkOutput("ovf_issue_count", 32'(iss_cnt), 32'd4);
    @(negedge clock);
    checkOutput("ovf_err_sticky", 32'(err), 32'h1);

    for (int r = 0; r < 8; r++)
      applyStimulus(int'($urandom_range(1, 20)), int'($urandom_range(1, 5)), 0, 1'b0);

    reset_mid_run();
    applyStimulus(5, 3, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
